vx_dispatch_queue: RTL

VX_DISPATCH_QUEUE -- requirements
Module: VX_dispatch_queue

---
 rtl/vx_dispatch_queue.sv | 120 ++++++++++++
 1 files changed

// File: rtl/vx_dispatch_queue.sv
// Dispatch queue: routes each request to one of NUM_CH per-channel FIFOs by ex_type.
// Out-of-range ex_types are NOPs that are accepted, counted and dropped.

module vx_dispatch_lane #(
  parameter int DATAW = 64,
  parameter int DEPTH = 2,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [DATAW-1:0] push_data,
  input  logic             pop_rdy,
  output logic             valid,
  output logic             full,
  output logic [DATAW-1:0] data,
  output logic [CNTW-1:0]  count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATAW-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             pop;

  assign valid = (count != '0);
  assign full  = (count == CNTW'(DEPTH));
  assign pop   = valid && pop_rdy && !flush;
  assign data  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // payload storage needs no reset; count gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

module vx_dispatch_queue #(
  parameter int NUM_CH = 5,
  parameter int DATAW  = 64,
  parameter int DEPTH  = 2,
  parameter int TYPEW  = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [TYPEW-1:0]                       in_ex_type,
  input  logic [DATAW-1:0]                       in_data,
  output logic [NUM_CH-1:0]                      out_valid,
  input  logic [NUM_CH-1:0]                      out_ready,
  output logic [NUM_CH*DATAW-1:0]                out_data,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]    out_count,
  output logic [15:0]                            nop_count,
  output logic                                   busy
);
  localparam int CNTW = $clog2(DEPTH) + 1;
  localparam logic [TYPEW:0] NUM_CH_W = (TYPEW+1)'(NUM_CH);

  typedef struct packed {
    logic [TYPEW-1:0] ex_type;
    logic [DATAW-1:0] data;
  } req_t;

  req_t              req;
  logic [NUM_CH-1:0] route, full, push;
  logic              is_nop, fire;

  assign req    = '{ex_type: in_ex_type, data: in_data};
  assign is_nop = ({1'b0, req.ex_type} >= NUM_CH_W);

  always_comb begin
    route = '0;
    for (int k = 0; k < NUM_CH; k++) route[k] = (req.ex_type == TYPEW'(k));
  end

  // ready looks only at occupancy, never at out_ready, so a full lane stays closed while popping
  assign in_ready = !flush && (is_nop || !(|(full & route)));
  assign fire     = in_valid && in_ready;
  assign push     = fire ? route : '0;
  assign busy     = |out_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  nop_count <= '0;
    else if (fire && is_nop && nop_count != '1)  nop_count <= nop_count + 16'd1;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    vx_dispatch_lane #(.DATAW(DATAW), .DEPTH(DEPTH), .CNTW(CNTW)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (push[k]),
      .push_data (req.data),
      .pop_rdy   (out_ready[k]),
      .valid     (out_valid[k]),
      .full      (full[k]),
      .data      (out_data[k*DATAW +: DATAW]),
      .count     (out_count[k*CNTW +: CNTW])
    );
  end
endmodule
